// File: rtl/oric_tap_parser.sv
// Streaming Oric .TAP parser: strips sync/header/name of the first program and writes its payload to RAM.
// Optional ORIC_TAP_MULTI_EN: keep parsing further files of the same image after the first one completes.
module oric_tap_parser #(
  parameter int MIN_SYNC = 3,
  parameter int MAX_NAME = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] tape_addr,
  output logic        tape_wr,
  output logic [7:0]  tape_dout,
  output logic [15:0] loadpoint,
  output logic        tape_autorun,
  output logic        tape_is_basic,
  output logic        tape_complete,
  output logic        tape_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_HEADER = 3'd2;
  localparam logic [2:0] S_NAME   = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [7:0] SYNC_MIN = 8'(MIN_SYNC);
  localparam logic [7:0] NAME_LIM = 8'(MAX_NAME);

  logic [2:0]  state, cur_state;
  logic [7:0]  sync_cnt, cur_sync, name_cnt;
  logic [3:0]  hdr_idx;
  logic [7:0]  flags_r, autorun_r;
  logic [15:0] end_addr, start_addr, wr_ptr;
  logic        fin_pend;
  logic        byte_v, restart, active;

  // An addr-0 byte is handled as if the parser were already in SYNC with an empty sync count.
  always_comb begin
    byte_v    = ioctl_download & ioctl_wr;
    restart   = byte_v && (ioctl_addr == '0);
    cur_state = restart ? S_SYNC : state;
    cur_sync  = restart ? '0 : sync_cnt;
    active    = (state == S_SYNC) || (state == S_HEADER) ||
                (state == S_NAME) || (state == S_DATA);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sync_cnt      <= '0;
      name_cnt      <= '0;
      hdr_idx       <= '0;
      flags_r       <= '0;
      autorun_r     <= '0;
      end_addr      <= '0;
      start_addr    <= '0;
      wr_ptr        <= '0;
      fin_pend      <= 1'b0;
      tape_addr     <= '0;
      tape_wr       <= 1'b0;
      tape_dout     <= '0;
      loadpoint     <= '0;
      tape_autorun  <= 1'b0;
      tape_is_basic <= 1'b0;
      tape_complete <= 1'b0;
      tape_error    <= 1'b0;
    end else begin
      tape_wr  <= 1'b0;
      fin_pend <= 1'b0;
      // Completion lands one cycle after the final write strobe; the first file's autorun wins.
      if (fin_pend) begin
        if (!tape_complete) tape_autorun <= (autorun_r != '0);
        tape_complete <= 1'b1;
      end
      if (restart) begin
        state         <= S_SYNC;
        sync_cnt      <= '0;
        fin_pend      <= 1'b0;
        loadpoint     <= '0;
        tape_autorun  <= 1'b0;
        tape_is_basic <= 1'b0;
        tape_complete <= 1'b0;
        tape_error    <= 1'b0;
      end
      if (active && !ioctl_download) begin
        state      <= S_ERROR;
        tape_error <= 1'b1;
      end else if (byte_v) begin
        case (cur_state)
          S_SYNC: begin
            if (ioctl_dout == 8'h16) begin
              sync_cnt <= (cur_sync == 8'hFF) ? cur_sync : cur_sync + 8'd1;
            end else if (ioctl_dout == 8'h24) begin
              if (cur_sync >= SYNC_MIN) begin
                state   <= S_HEADER;
                hdr_idx <= '0;
              end else begin
                state      <= S_ERROR;
                tape_error <= 1'b1;
              end
            end else begin
              sync_cnt <= '0;
            end
          end
          S_HEADER: begin
            hdr_idx <= hdr_idx + 4'd1;
            case (hdr_idx)
              4'd2: flags_r           <= ioctl_dout;
              4'd3: autorun_r         <= ioctl_dout;
              4'd4: end_addr[15:8]    <= ioctl_dout;
              4'd5: end_addr[7:0]     <= ioctl_dout;
              4'd6: start_addr[15:8]  <= ioctl_dout;
              4'd7: start_addr[7:0]   <= ioctl_dout;
              4'd8: begin
                if (end_addr < start_addr) begin
                  state      <= S_ERROR;
                  tape_error <= 1'b1;
                end else begin
                  state    <= S_NAME;
                  name_cnt <= '0;
                  if (!tape_complete) begin
                    loadpoint     <= start_addr;
                    tape_is_basic <= (flags_r == 8'h00);
                  end
                end
              end
              default: ;
            endcase
          end
          S_NAME: begin
            if (ioctl_dout == 8'h00) begin
              state  <= S_DATA;
              wr_ptr <= start_addr;
            end else if (name_cnt == NAME_LIM) begin
              state      <= S_ERROR;
              tape_error <= 1'b1;
            end else begin
              name_cnt <= name_cnt + 8'd1;
            end
          end
          S_DATA: begin
            tape_wr   <= 1'b1;
            tape_addr <= wr_ptr;
            tape_dout <= ioctl_dout;
            if (wr_ptr == end_addr) begin
              fin_pend <= 1'b1;
`ifdef ORIC_TAP_MULTI_EN
              state    <= S_SYNC;
              sync_cnt <= '0;
`else
              state    <= S_DONE;
`endif
            end else begin
              wr_ptr <= wr_ptr + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oric_tap_parser.sv
// Directed bench for oric_tap_parser: hand-built .TAP images with expected RAM writes and status outputs.
module tb_oric_tap_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] tape_addr;
  logic        tape_wr;
  logic [7:0]  tape_dout;
  logic [15:0] loadpoint;
  logic        tape_autorun;
  logic        tape_is_basic;
  logic        tape_complete;
  logic        tape_error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  img[$];
  int          pos;
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];

  oric_tap_parser #(.MIN_SYNC(3), .MAX_NAME(16)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .tape_addr(tape_addr), .tape_wr(tape_wr),
    .tape_dout(tape_dout), .loadpoint(loadpoint), .tape_autorun(tape_autorun),
    .tape_is_basic(tape_is_basic), .tape_complete(tape_complete), .tape_error(tape_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tape_wr === 1'b1) begin
      wr_a.push_back(tape_addr);
      wr_d.push_back(tape_dout);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_image();
    img.delete(); pos = 0;
    wr_a.delete(); wr_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic push(input logic [7:0] b);
    img.push_back(b);
  endtask

  task automatic expw(input logic [15:0] a, input logic [7:0] d);
    exp_a.push_back(a); exp_d.push_back(d);
  endtask

  // Sync x3, marker, 9-byte header, name "A", terminator: 15 bytes.
  task automatic hdr(input logic [7:0] flags, input logic [7:0] ar,
                     input logic [15:0] e, input logic [15:0] s);
    push(8'h16); push(8'h16); push(8'h16); push(8'h24);
    push(8'h00); push(8'h00); push(flags); push(ar);
    push(e[15:8]); push(e[7:0]); push(s[15:8]); push(s[7:0]); push(8'h00);
    push(8'h41); push(8'h00);
  endtask

  // Returns on the falling edge after the byte was taken, where its write strobe is visible.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic play_to(input int last);
    while (pos <= last && pos < img.size()) begin
      send_byte(25'(pos), img[pos]);
      pos++;
    end
  endtask

  task automatic end_download();
    @(negedge clk); ioctl_download = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), 32'(wr_a[i]), 32'(exp_a[i]));
      chk($sformatf("%s_wd%0d", tag, i), 32'(wr_d[i]), 32'(exp_d[i]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(tape_addr), 32'h0);
    chk({tag, "_wr"}, 32'(tape_wr), 32'h0);
    chk({tag, "_dout"}, 32'(tape_dout), 32'h0);
    chk({tag, "_lp"}, 32'(loadpoint), 32'h0);
    chk({tag, "_ar"}, 32'(tape_autorun), 32'h0);
    chk({tag, "_basic"}, 32'(tape_is_basic), 32'h0);
    chk({tag, "_cmp"}, 32'(tape_complete), 32'h0);
    chk({tag, "_err"}, 32'(tape_error), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset_n = 1'b1;

    // 1: minimal autorun file
    new_image(); hdr(8'h80, 8'hC7, 16'h0502, 16'h0500);
    push(8'hAA); push(8'hBB); push(8'hCC);
    expw(16'h0500, 8'hAA); expw(16'h0501, 8'hBB); expw(16'h0502, 8'hCC);
    play_to(16);
    play_to(17);
    chk("t1_lastwr", 32'(tape_wr), 32'h1);
    chk("t1_lastaddr", 32'(tape_addr), 32'h0502);
    chk("t1_cmp_early", 32'(tape_complete), 32'h0);
    chk("t1_ar_early", 32'(tape_autorun), 32'h0);
    @(negedge clk);
    chk("t1_cmp", 32'(tape_complete), 32'h1);
    chk("t1_ar", 32'(tape_autorun), 32'h1);
    chk("t1_wr_off", 32'(tape_wr), 32'h0);
    end_download();
    chk_writes("t1");
    chk("t1_err", 32'(tape_error), 32'h0);
    chk("t1_lp", 32'(loadpoint), 32'h0500);
    chk("t1_basic", 32'(tape_is_basic), 32'h0);
    chk("t1_cmp_hold", 32'(tape_complete), 32'h1);

    // 2: end < start
    new_image(); hdr(8'h00, 8'h00, 16'h05FF, 16'h0600);
    push(8'h11); push(8'h22);
    play_to(11);
    chk("t2_err_early", 32'(tape_error), 32'h0);
    play_to(12);
    chk("t2_err", 32'(tape_error), 32'h1);
    play_to(99);
    end_download();
    chk_writes("t2");
    chk("t2_cmp", 32'(tape_complete), 32'h0);

    // 3: download drops mid-payload
    new_image(); hdr(8'h00, 8'h00, 16'h0503, 16'h0500);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    expw(16'h0500, 8'h01); expw(16'h0501, 8'h02);
    play_to(16);
    end_download();
    chk_writes("t3");
    chk("t3_err", 32'(tape_error), 32'h1);
    chk("t3_cmp", 32'(tape_complete), 32'h0);

    // 4: single byte at 0xFFFF, trailing bytes ignored
    new_image(); hdr(8'h00, 8'h00, 16'hFFFF, 16'hFFFF);
    push(8'h5A); push(8'h6B); push(8'h7C);
    expw(16'hFFFF, 8'h5A);
    play_to(99);
    end_download();
    chk_writes("t4");
    chk("t4_cmp", 32'(tape_complete), 32'h1);
    chk("t4_err", 32'(tape_error), 32'h0);
    chk("t4_lp", 32'(loadpoint), 32'hFFFF);
    chk("t4_basic", 32'(tape_is_basic), 32'h1);
    chk("t4_ar", 32'(tape_autorun), 32'h0);

    // 5a: short sync errors, then a fresh download recovers
    new_image(); push(8'h16); push(8'h24); push(8'h00);
    play_to(99);
    end_download();
    chk("t5_err", 32'(tape_error), 32'h1);
    chk_writes("t5bad");
    new_image(); hdr(8'h00, 8'h01, 16'h0301, 16'h0300);
    push(8'h9A); push(8'h9B);
    expw(16'h0300, 8'h9A); expw(16'h0301, 8'h9B);
    play_to(0);
    chk("t5_err_clr", 32'(tape_error), 32'h0);
    play_to(99);
    end_download();
    chk_writes("t5ok");
    chk("t5_cmp", 32'(tape_complete), 32'h1);
    chk("t5_ar", 32'(tape_autorun), 32'h1);
    chk("t5_lp", 32'(loadpoint), 32'h0300);

    // 5b: reset mid-DATA, later bytes ignored until a new addr-0 byte
    new_image(); hdr(8'h00, 8'h00, 16'h0403, 16'h0400);
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    play_to(15);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    chk_zero("t5rst");
    reset_n = 1'b1;
    wr_a.delete(); wr_d.delete();
    play_to(99);
    end_download();
    chk_writes("t5ign");
    chk("t5ign_cmp", 32'(tape_complete), 32'h0);
    pos = 0;
    expw(16'h0400, 8'hD1); expw(16'h0401, 8'hD2); expw(16'h0402, 8'hD3); expw(16'h0403, 8'hD4);
    play_to(99);
    end_download();
    chk_writes("t5re");
    chk("t5re_cmp", 32'(tape_complete), 32'h1);

    // 6: two concatenated files
    new_image(); hdr(8'h00, 8'h01, 16'h0501, 16'h0500);
    push(8'h11); push(8'h22);
    hdr(8'h80, 8'h00, 16'h0700, 16'h0700);
    push(8'h33);
    expw(16'h0500, 8'h11); expw(16'h0501, 8'h22);
`ifdef ORIC_TAP_MULTI_EN
    expw(16'h0700, 8'h33);
`endif
    play_to(99);
    end_download();
    chk_writes("t6");
    chk("t6_lp", 32'(loadpoint), 32'h0500);
    chk("t6_cmp", 32'(tape_complete), 32'h1);
    chk("t6_ar", 32'(tape_autorun), 32'h1);
    chk("t6_basic", 32'(tape_is_basic), 32'h1);
    chk("t6_err", 32'(tape_error), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
